// File: rtl/router_pkg.sv
// Shared constants for the 1x3 router: data width, buffer geometry and header layout.
package router_pkg;
    localparam int WIDTH    = 8;
    localparam int DEPTH    = 16;
    localparam int ADDR_W   = 4;
    localparam int LEN_MSB  = 7;
    localparam int LEN_LSB  = 2;
    localparam int ADDR_MSB = 1;
    localparam int ADDR_LSB = 0;
    localparam int NPORTS   = 3;
    // Remaining-bytes counter is one bit wider than the length field so a length of 63 loads 64.
    localparam int CNT_W    = 7;
endpackage

// File: rtl/router_fifo.sv
// Per-port output buffer: tagged byte FIFO with one-cycle registered read and packet-boundary tracking.
module router_fifo #(
    parameter int WIDTH  = router_pkg::WIDTH,
    parameter int DEPTH  = router_pkg::DEPTH,
    parameter int ADDR_W = router_pkg::ADDR_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             soft_reset,
    input  logic             write_enb,
    input  logic             read_enb,
    input  logic             lfd_state,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty,
    output logic             pkt_busy
);
    import router_pkg::*;

    logic [WIDTH:0]   mem_q [DEPTH];
    logic [ADDR_W:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic [WIDTH:0]   rd_word;
    logic             wr_fire;
    logic             rd_fire;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                      (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    assign pkt_busy = (pkt_cnt_q != '0);
    assign data_out = data_out_q;
    assign rd_word  = mem_q[rd_ptr_q[ADDR_W-1:0]];

    // A flush in the same cycle discards any concurrent write or read.
    assign wr_fire = write_enb && !full && !soft_reset && !reset;
    assign rd_fire = read_enb && !empty && !soft_reset && !reset;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        pkt_cnt_d  = pkt_cnt_q;
        data_out_d = data_out_q;
        if (soft_reset) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            pkt_cnt_d  = '0;
            data_out_d = '0;
        end else begin
            if (wr_fire) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (rd_fire) begin
                rd_ptr_d   = rd_ptr_q + 1'b1;
                data_out_d = rd_word[WIDTH-1:0];
                if (rd_word[WIDTH]) begin
                    pkt_cnt_d = CNT_W'(rd_word[LEN_MSB:LEN_LSB]) + CNT_W'(1);
                end else if (pkt_cnt_q != '0) begin
                    pkt_cnt_d = pkt_cnt_q - 1'b1;
                end
            end else if (pkt_cnt_q == '0) begin
                // Outside a packet the output idles at zero; mid-packet it holds between reads.
                data_out_d = '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            pkt_cnt_q  <= '0;
            data_out_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            pkt_cnt_q  <= pkt_cnt_d;
            data_out_q <= data_out_d;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_fire) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= {lfd_state, data_in};
        end
    end
endmodule

// File: tb/tb_router_fifo.sv
// Scoreboard bench for router_fifo: stimulus queues expected read data, a monitor checks each read.
module tb_router_fifo;
    localparam int DEPTH = 16;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       soft_reset = 1'b0;
    logic       write_enb = 1'b0;
    logic       read_enb = 1'b0;
    logic       lfd_state = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic       full, empty, pkt_busy;

    int total = 0;
    int bad = 0;

    logic [8:0] mdl[$];
    logic [7:0] sb[$];
    logic [7:0] mon_exp;
    logic       saw_full;

    router_fifo dut (
        .clock      (clock),
        .reset      (reset),
        .soft_reset (soft_reset),
        .write_enb  (write_enb),
        .read_enb   (read_enb),
        .lfd_state  (lfd_state),
        .data_in    (data_in),
        .data_out   (data_out),
        .full       (full),
        .empty      (empty),
        .pkt_busy   (pkt_busy)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    always @(posedge clock) begin
        if (!reset && !soft_reset && read_enb && !empty) begin
            #1;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL rd_unexpected data_out=%h required no read", data_out);
            end else begin
                mon_exp = sb.pop_front();
                if (data_out !== mon_exp) begin
                    bad++;
                    $display("FAIL rd_data data_out=%h required=%h", data_out, mon_exp);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [7:0] d, input logic tag);
        write_enb = 1'b1;
        data_in   = d;
        lfd_state = tag;
        if (mdl.size() < DEPTH) mdl.push_back({tag, d});
        @(negedge clock);
        write_enb = 1'b0;
        lfd_state = 1'b0;
    endtask

    task automatic rd();
        logic [8:0] e;
        read_enb = 1'b1;
        if (mdl.size() > 0) begin
            e = mdl.pop_front();
            sb.push_back(e[7:0]);
        end
        @(negedge clock);
        read_enb = 1'b0;
    endtask

    task automatic both(input logic [7:0] d, input logic tag);
        logic [8:0] e;
        bit pre_full, pre_empty;
        pre_full  = (mdl.size() == DEPTH);
        pre_empty = (mdl.size() == 0);
        if (!pre_empty) begin
            e = mdl.pop_front();
            sb.push_back(e[7:0]);
        end
        if (!pre_full) mdl.push_back({tag, d});
        write_enb = 1'b1;
        read_enb  = 1'b1;
        data_in   = d;
        lfd_state = tag;
        @(negedge clock);
        write_enb = 1'b0;
        read_enb  = 1'b0;
        lfd_state = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mdl.delete();
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clock);
        reset = 1'b0;
        chk("reset_empty", empty, 1);
        chk("reset_full", full, 0);
        chk("reset_busy", pkt_busy, 0);
        chk("reset_dout", data_out, 0);

        // Single packet: header 0D (len 3), three payload bytes, parity.
        wr(8'h0D, 1'b1);
        wr(8'hA1, 1'b0);
        wr(8'hA2, 1'b0);
        wr(8'hA3, 1'b0);
        wr(8'h5C, 1'b0);
        rd(); chk("busy_after_hdr", pkt_busy, 1);
        rd(); chk("busy_after_p1", pkt_busy, 1);
        rd(); chk("busy_after_p2", pkt_busy, 1);
        rd(); chk("busy_after_p3", pkt_busy, 1);
        rd(); chk("busy_after_parity", pkt_busy, 0);
        chk("parity_shown", data_out, 8'h5C);
        @(negedge clock);
        chk("dout_idle_clear", data_out, 0);
        chk("pkt_empty_end", empty, 1);

        // Fill to full, drop a 17th write, drain.
        do_reset();
        for (int i = 0; i < 16; i++) wr(8'h30 + 8'(i), 1'b0);
        chk("fill_full", full, 1);
        wr(8'hFF, 1'b0);
        chk("overflow_full", full, 1);
        for (int i = 0; i < 16; i++) rd();
        chk("drain_empty", empty, 1);
        @(negedge clock);
        chk("drain_dout_clear", data_out, 0);
        chk("drain_sb", sb.size(), 0);

        // Simultaneous strobes at full, then at empty with a packet still open.
        do_reset();
        wr(8'h40, 1'b1);
        for (int i = 1; i < 16; i++) wr(8'h10 + 8'(i), 1'b0);
        both(8'hEE, 1'b0);
        chk("both_full_notfull", full, 0);
        chk("both_full_notempty", empty, 0);
        for (int i = 0; i < 15; i++) rd();
        chk("both_drain_empty", empty, 1);
        both(8'h77, 1'b0);
        chk("both_empty_hold", data_out, 8'h1F);
        chk("both_empty_notempty", empty, 0);
        chk("both_empty_busy", pkt_busy, 1);
        rd();
        chk("both_sb", sb.size(), 0);

        // Soft reset concurrent with a write.
        do_reset();
        wr(8'h09, 1'b1);
        for (int i = 0; i < 5; i++) wr(8'hB0 + 8'(i), 1'b0);
        rd();
        chk("pre_soft_busy", pkt_busy, 1);
        soft_reset = 1'b1;
        write_enb  = 1'b1;
        data_in    = 8'hC3;
        mdl.delete();
        @(negedge clock);
        soft_reset = 1'b0;
        write_enb  = 1'b0;
        chk("soft_empty", empty, 1);
        chk("soft_full", full, 0);
        chk("soft_dout", data_out, 0);
        chk("soft_busy", pkt_busy, 0);
        rd();
        chk("soft_rd_empty_dout", data_out, 0);
        chk("soft_rd_empty", empty, 1);

        // Pointer wrap with interleaved write/read pairs.
        do_reset();
        saw_full = 1'b0;
        for (int i = 0; i < 40; i++) begin
            wr(8'(i + 1), 1'b0);
            if (full) saw_full = 1'b1;
            rd();
            if (full) saw_full = 1'b1;
        end
        chk("wrap_no_full", saw_full, 0);
        chk("wrap_empty", empty, 1);
        chk("wrap_sb", sb.size(), 0);

        // Global reset mid-packet.
        do_reset();
        wr(8'h0D, 1'b1);
        wr(8'hA1, 1'b0);
        wr(8'hA2, 1'b0);
        rd();
        rd();
        chk("mid_busy", pkt_busy, 1);
        chk("mid_dout", data_out, 8'hA1);
        do_reset();
        chk("midrst_busy", pkt_busy, 0);
        chk("midrst_dout", data_out, 0);
        chk("midrst_empty", empty, 1);
        chk("final_sb", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
